// File: rtl/tx_drain_pkg.sv
// Shared types and constants for the transmit-drain controller.
// Used by tx_drain_ctrl, its byte serializer and its port interface.
package tx_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEQ  = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } tx_drain_state_t;

    localparam int BLOCK_W_DEF = 64;
    localparam int BYTE_W      = 8;

endpackage

// File: rtl/tx_drain_ctrl_if.sv
// Port bundle between the Tx FIFO / host stream and tx_drain_ctrl.
// Optional macro TX_DRAIN_PARITY_EN adds out_parity and parity_odd.
interface tx_drain_ctrl_if
    import tx_drain_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int CNT_W   = 8
);
    logic               emptyTx;
    logic [BLOCK_W-1:0] tx_rdata;
    logic               trans_deq;
    logic [BYTE_W-1:0]  out_byte;
    logic               out_valid;
    logic               out_ready;
    logic               block_sent;
    logic               busy;
    logic [CNT_W-1:0]   block_count;
`ifdef TX_DRAIN_PARITY_EN
    logic               out_parity;
    logic               parity_odd;

    modport master (
        input  emptyTx, tx_rdata, out_ready, parity_odd,
        output trans_deq, out_byte, out_valid, block_sent, busy, block_count, out_parity
    );
    modport slave (
        output emptyTx, tx_rdata, out_ready, parity_odd,
        input  trans_deq, out_byte, out_valid, block_sent, busy, block_count, out_parity
    );
`else
    modport master (
        input  emptyTx, tx_rdata, out_ready,
        output trans_deq, out_byte, out_valid, block_sent, busy, block_count
    );
    modport slave (
        output emptyTx, tx_rdata, out_ready,
        input  trans_deq, out_byte, out_valid, block_sent, busy, block_count
    );
`endif
endinterface

// File: rtl/tx_byte_serializer.sv
// Holds one cipher block and presents it MSB-first as bytes on a valid/ready
// handshake; flags the acceptance of the final byte.
module tx_byte_serializer
    import tx_drain_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEF
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] data,
    input  logic               send_en,
    input  logic               out_ready,
    output logic [BYTE_W-1:0]  out_byte,
    output logic               out_valid,
    output logic               last_accept
);
    localparam int NBYTES = BLOCK_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [BLOCK_W-1:0] shreg;
    logic [IDX_W-1:0]   byte_idx;
    logic               accept;

    assign out_valid   = send_en;
    assign accept      = send_en && out_ready;
    // Byte is forced to zero outside SEND so no stale data is ever visible.
    assign out_byte    = send_en ? shreg[BLOCK_W-1 -: BYTE_W] : '0;
    assign last_accept = accept && (byte_idx == IDX_W'(NBYTES - 1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            shreg    <= data;
            byte_idx <= '0;
        end else if (accept) begin
            shreg    <= shreg << BYTE_W;
            byte_idx <= byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tx_drain_ctrl.sv
// Drains cipher blocks from the Tx FIFO and streams them out byte-wise.
// Optional macro TX_DRAIN_PARITY_EN adds a per-byte parity output.
module tx_drain_ctrl
    import tx_drain_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            n_reset,
    tx_drain_ctrl_if.master bus
);
    tx_drain_state_t  state_q;
    tx_drain_state_t  state_d;
    logic             last_accept;
    logic             block_sent_q;
    logic [CNT_W-1:0] block_count_q;
    logic [BYTE_W-1:0] out_byte;
    logic             out_valid;

    tx_byte_serializer #(
        .BLOCK_W (BLOCK_W)
    ) u_ser (
        .clk         (clk),
        .n_reset     (n_reset),
        .load        (state_q == LOAD),
        .data        (bus.tx_rdata),
        .send_en     (state_q == SEND),
        .out_ready   (bus.out_ready),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .last_accept (last_accept)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            block_sent_q  <= 1'b0;
            block_count_q <= '0;
        end else begin
            state_q      <= state_d;
            block_sent_q <= last_accept;
            if (last_accept) begin
                block_count_q <= block_count_q + 1'b1;
            end
        end
    end

    // emptyTx is only consulted in IDLE and at the final byte handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.emptyTx) state_d = DEQ;
            DEQ:     state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (last_accept) state_d = bus.emptyTx ? IDLE : DEQ;
            default: state_d = IDLE;
        endcase
    end

    assign bus.trans_deq   = (state_q == DEQ);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_byte    = out_byte;
    assign bus.out_valid   = out_valid;
    assign bus.block_sent  = block_sent_q;
    assign bus.block_count = block_count_q;

`ifdef TX_DRAIN_PARITY_EN
    assign bus.out_parity = out_valid & ((^out_byte) ^ bus.parity_odd);
`endif

endmodule

// File: tb/tb_tx_drain_ctrl.sv
// Self-checking bench for tx_drain_ctrl: FIFO model plus byte-stream scoreboard.
// Parity checks are included when TX_DRAIN_PARITY_EN is defined.
module tb_tx_drain_ctrl;
    import tx_drain_pkg::*;

    logic clk;
    logic n_reset;

    tx_drain_ctrl_if #(.BLOCK_W(64), .CNT_W(8)) bus ();

    tx_drain_ctrl #(.BLOCK_W(64), .CNT_W(8)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: producer index written by the stimulus, consumer index by the read port.
    logic [63:0] mem [1024];
    int          n_push = 0;
    int          n_pop  = 0;

    assign bus.emptyTx = (n_push == n_pop);

    always @(posedge clk) begin
        if (bus.trans_deq) begin
            bus.tx_rdata <= mem[n_pop % 1024];
            n_pop        <= n_pop + 1;
        end
    end

    // Reference model: expected byte stream and block accounting.
    logic [7:0] exp_q [$];
    logic [7:0] exp_count = 8'd0;
    int         bytes_acc = 0;
    logic       sent_pend = 1'b0;
    logic       hold      = 1'b0;
    logic [7:0] hold_byte = 8'd0;

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] blk);
        mem[n_push % 1024] = blk;
        n_push++;
        for (int i = 7; i >= 0; i--) exp_q.push_back(blk[i*8 +: 8]);
    endtask

    // One clock cycle: drive out_ready at the falling edge, then score the cycle.
    task automatic cyc(input logic rdy);
        @(negedge clk);
        bus.out_ready = rdy;
        if (bus.trans_deq) chk("deq_nonempty", 64'(n_push != n_pop), 64'(1));
        chk("block_sent", 64'(bus.block_sent), 64'(sent_pend));
        chk("block_count", 64'(bus.block_count), 64'(exp_count));
        sent_pend = 1'b0;
        if (bus.out_valid) begin
            chk("no_bubble", 64'(exp_q.size() != 0), 64'(1));
            if (hold) chk("hold_stable", 64'(bus.out_byte), 64'(hold_byte));
            if (exp_q.size() != 0) begin
                chk("byte", 64'(bus.out_byte), 64'(exp_q[0]));
`ifdef TX_DRAIN_PARITY_EN
                chk("parity", 64'(bus.out_parity), 64'((^exp_q[0]) ^ bus.parity_odd));
`endif
                if (rdy) begin
                    void'(exp_q.pop_front());
                    bytes_acc++;
                    if (bytes_acc % 8 == 0) begin
                        sent_pend = 1'b1;
                        exp_count++;
                    end
                end
            end
            hold      = !rdy;
            hold_byte = bus.out_byte;
        end else begin
            hold = 1'b0;
`ifdef TX_DRAIN_PARITY_EN
            chk("parity_idle", 64'(bus.out_parity), 64'(0));
`endif
        end
    endtask

    // A single block under constant out_ready, with the fixed cycle timeline.
    task automatic run_single(input logic [63:0] blk);
        push(blk);
        for (int c = 1; c <= 12; c++) begin
            cyc(1'b1);
            chk("t_deq", 64'(bus.trans_deq), 64'(c == 1));
            chk("t_valid", 64'(bus.out_valid), 64'(c >= 3 && c <= 10));
            chk("t_busy", 64'(bus.busy), 64'(c >= 1 && c <= 10));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_deq"}, 64'(bus.trans_deq), 64'(0));
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_byte"}, 64'(bus.out_byte), 64'(0));
        chk({tag, "_sent"}, 64'(bus.block_sent), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_count"}, 64'(bus.block_count), 64'(0));
`ifdef TX_DRAIN_PARITY_EN
        chk({tag, "_parity"}, 64'(bus.out_parity), 64'(0));
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   nvalid;
        int   guard;
        logic [7:0] base;

        n_reset       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef TX_DRAIN_PARITY_EN
        bus.parity_odd = 1'b0;
`endif
        #1;
        chk_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        // Single block, MSB first.
        run_single(64'h0123456789ABCDEF);
        chk("single_count", 64'(bus.block_count), 64'(1));

        // Back-pressure: out_ready low on alternate cycles.
        push(64'h0123456789ABCDEF);
        nvalid = 0;
        for (int c = 1; c <= 22; c++) begin
            cyc(1'(c % 2 == 0));
            if (bus.out_valid) nvalid++;
        end
        chk("bp_send_cycles", 64'(nvalid), 64'(16));
        chk("bp_count", 64'(bus.block_count), 64'(2));

        // Back-to-back blocks.
        push(64'hFFFF_FFFF_FFFF_FFFF);
        push(64'h0000_0000_0000_0000);
        for (int c = 1; c <= 22; c++) begin
            cyc(1'b1);
            chk("b2b_deq", 64'(bus.trans_deq), 64'(c == 1 || c == 11));
            chk("b2b_busy", 64'(bus.busy), 64'(c >= 1 && c <= 20));
        end
        chk("b2b_count", 64'(bus.block_count), 64'(4));

        // Empty FIFO: nothing happens.
        for (int c = 0; c < 50; c++) begin
            cyc(1'($urandom_range(0, 1)));
            chk("empty_deq", 64'(bus.trans_deq), 64'(0));
            chk("empty_valid", 64'(bus.out_valid), 64'(0));
            chk("empty_busy", 64'(bus.busy), 64'(0));
        end

        // Reset after the third byte of a block is accepted.
        push({$urandom, $urandom});
        for (int c = 1; c <= 5; c++) cyc(1'b1);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (5) void'(exp_q.pop_front());
        exp_count = 8'd0;
        bytes_acc = 0;
        sent_pend = 1'b0;
        hold      = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        run_single({$urandom, $urandom});
        chk("after_rst_count", 64'(bus.block_count), 64'(1));

`ifdef TX_DRAIN_PARITY_EN
        // Parity on byte 0x07, held under back-pressure.
        push({8'h07, 24'($urandom), $urandom});
        for (int c = 1; c <= 3; c++) cyc(1'b0);
        bus.parity_odd = 1'b0;
        #1;
        chk("par_07_even", 64'(bus.out_parity), 64'(1));
        bus.parity_odd = 1'b1;
        #1;
        chk("par_07_odd", 64'(bus.out_parity), 64'(0));
        for (int c = 0; c < 12; c++) cyc(1'b1);
        bus.parity_odd = 1'b0;
`endif

        // 256 random blocks with random back-pressure: counter wraps back to its start.
        base = exp_count;
        for (int b = 0; b < 256; b++) push({$urandom, $urandom});
        guard = 0;
        while ((exp_q.size() != 0 || sent_pend) && guard < 20000) begin
            cyc(1'($urandom_range(0, 3) != 0));
            guard++;
        end
        chk("wrap_timeout", 64'(guard < 20000), 64'(1));
        chk("wrap_count", 64'(bus.block_count), 64'(base));
        cyc(1'b1);
        chk("wrap_idle_busy", 64'(bus.busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_drain_ctrl.md
Name: tx_drain_ctrl

Overview:
- Transmit-side counterpart of the MCU receive/dequeue control.
- Drains 64-bit processed cipher blocks from the transmit FIFO (Tx FIFO) and serialises each block onto a byte-wide valid/ready stream towards the host interface, most significant byte first.
- Reports busy/idle status and a running block count, which the MCU folds into its status reporting.

Parameters:
- BLOCK_W, 64, width of one cipher block read from the Tx FIFO; must be a multiple of 8.
- NBYTES, BLOCK_W/8, bytes per block; derived, not overridden.
- CNT_W, 8, width of the block_count counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- n_reset  input  1  asynchronous active-low reset.
- emptyTx  input  1  Tx FIFO empty flag.
- tx_rdata  input  BLOCK_W  Tx FIFO read data; valid the cycle after trans_deq (registered-read FIFO).
- trans_deq  output  1  one-cycle Tx FIFO dequeue strobe.
- out_byte  output  8  current output byte.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  host accepts the byte when out_valid && out_ready.
- block_sent  output  1  one-cycle pulse when the last byte of a block is accepted.
- busy  output  1  high in any state except IDLE.
- block_count  output  CNT_W  number of blocks fully sent since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, n_reset=0) forces:
  - state=IDLE; shift register and byte counter cleared.
  - trans_deq=0, out_valid=0, out_byte=0, block_sent=0, busy=0, block_count=0.
- A reset asserted mid-block discards the partial block. The bytes of that block already dequeued are lost; this is the decided behaviour.
- FSM states: IDLE, DEQ, LOAD, SEND.
- IDLE:
  - if !emptyTx, go to DEQ; otherwise stay in IDLE.
- DEQ:
  - trans_deq=1 for exactly this cycle (combinational decode of state); go to LOAD.
- LOAD:
  - capture tx_rdata into the shift register; byte_idx=0; go to SEND.
- SEND:
  - out_valid=1 and out_byte=shreg[BLOCK_W-1 -: 8].
  - On out_valid && out_ready: shift left by 8 and increment byte_idx.
  - If out_ready=0, out_byte and out_valid hold stable; no other state changes.
- Last-byte handshake in SEND (byte_idx==NBYTES-1):
  - block_sent pulses in the following cycle (registered); block_count increments in the same cycle.
  - If emptyTx=0 at that edge, go to DEQ; otherwise go to IDLE.
- Latency, FIFO non-empty in IDLE to first out_valid: 3 cycles (IDLE→DEQ→LOAD→SEND).
- Throughput: 8 bytes per NBYTES+2 cycles under continuous out_ready.
- Never dequeue on empty: trans_deq is issued only from DEQ, which is entered only when emptyTx=0 was sampled.
- emptyTx toggling during SEND has no effect until the last-byte handshake.
- block_count wraps from 2^CNT_W-1 to 0 with no flag.
- out_valid is deasserted in IDLE, DEQ and LOAD; no bubble byte is ever presented.

Optional Feature:
- Macro TX_DRAIN_PARITY_EN.
- When defined:
  - adds output port out_parity (1 bit) = ^out_byte (even parity over the presented byte), valid whenever out_valid=1 and 0 otherwise, including at reset.
  - adds input parity_odd (1 bit); when 1, out_parity is inverted.
- When undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Shared package tx_drain_pkg:
  - enum tx_drain_state_t {IDLE, DEQ, LOAD, SEND} as a 2-bit logic enum.
  - localparams BLOCK_W_DEF=64 and BYTE_W=8.
- One natural sub-module, tx_byte_serializer: the shift register, byte_idx and the valid/ready handshake (load strobe in; last_accept out).
- FSM and counter stay in the top module.

Test Plan:
- Single block: FIFO holds 0x0123456789ABCDEF, out_ready=1 constantly.
  - trans_deq pulses once at cycle 1.
  - Bytes 01,23,45,67,89,AB,CD,EF on cycles 3–10.
  - block_sent pulses at cycle 11; block_count=1; then IDLE with busy=0.
- Back-pressure: same block, out_ready low on every other cycle.
  - Each byte is held stable while out_ready=0; sequence unchanged; 16 cycles in SEND.
- Back-to-back: FIFO holds two blocks 0xFFFF...FF and 0x0000...00.
  - Second trans_deq occurs the cycle after the last byte of block 1 is accepted.
  - 16 bytes emitted; block_count=2.
- Empty FIFO: emptyTx=1 for 50 cycles.
  - trans_deq never asserts; out_valid=0; busy=0.
- Mid-block reset: n_reset=0 after byte 3 of a block is accepted.
  - All outputs return to reset values asynchronously; block_count=0.
  - The next FIFO block is sent from its first byte.
- Wrap and parity (TX_DRAIN_PARITY_EN):
  - 256 blocks sent: block_count returns to 0.
  - Byte 0x07 with parity_odd=0: out_parity=1; with parity_odd=1: out_parity=0.
